// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
//   Multi-cycle CPU control unit. A six-state sequencer (IF, ID, EXE, MEM,
//   WB, HALT) steps each instruction through the datapath. The control
//   outputs are decoded combinationally from the current state and the
//   opcode held in IR. Only PCSrc in EXE looks at Zero/Sign.
//
//   Optional feature: when the macro MC_INSTR_COUNT_EN is defined, a 32-bit
//   retired-instruction counter drives InstrCount. Without the macro,
//   InstrCount is tied to zero and no counter register exists.
//
// Ports
//   CLK        in   1  clock, all state changes on the rising edge
//   Reset      in   1  synchronous active-high reset
//   Opcode     in   6  IR[31:26]
//   Zero       in   1  ALU result is zero
//   Sign       in   1  ALU result bit 31
//   MemReady   in   1  data memory access complete
//   State      out  3  current state encoding
//   PCWre      out  1  PC write enable (once per instruction)
//   IRWre      out  1  IR write enable
//   RegWre     out  1  register-file write enable
//   mWR/mRD    out  1  data memory write / read strobes
//   ALUSrcA    out  1  ALU A operand select (shift amount for sll)
//   ALUSrcB    out  1  ALU B operand select (immediate)
//   DBDataSrc  out  1  write-back data select (memory for lw)
//   ExtSel     out  1  immediate extend: 0 zero-extend, 1 sign-extend
//   WrRegDSrc  out  1  register write data: 0 PC+4, 1 datapath
//   RegDst     out  2  00 $31, 01 rt, 10 rd
//   PCSrc      out  2  00 PC+4, 01 branch, 10 jr, 11 j/jal
//   ALUOp      out  3  ALU function
//   InstrCount out 32  retired-instruction count
// ---------------------------------------------------------------------------
module mc_control_fsm (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [5:0]  Opcode,
  input  logic        Zero,
  input  logic        Sign,
  input  logic        MemReady,
  output logic [2:0]  State,
  output logic        PCWre,
  output logic        IRWre,
  output logic        RegWre,
  output logic        mWR,
  output logic        mRD,
  output logic        ALUSrcA,
  output logic        ALUSrcB,
  output logic        DBDataSrc,
  output logic        ExtSel,
  output logic        WrRegDSrc,
  output logic [1:0]  RegDst,
  output logic [1:0]  PCSrc,
  output logic [2:0]  ALUOp,
  output logic [31:0] InstrCount
);

  typedef enum logic [2:0] {
    ST_IF   = 3'b000,
    ST_ID   = 3'b001,
    ST_EXE  = 3'b010,
    ST_MEM  = 3'b011,
    ST_WB   = 3'b100,
    ST_HALT = 3'b101
  } state_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLT   = 6'b011000;
  localparam logic [5:0] OP_SLL   = 6'b011100;
  localparam logic [5:0] OP_SW    = 6'b100110;
  localparam logic [5:0] OP_LW    = 6'b100111;
  localparam logic [5:0] OP_BEQ   = 6'b110000;
  localparam logic [5:0] OP_BNE   = 6'b110001;
  localparam logic [5:0] OP_BLTZ  = 6'b110010;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  state_t state_r;
  state_t dec_state_s;

  logic is_lw_s, is_sw_s, is_beq_s, is_bne_s, is_bltz_s;
  logic is_j_s, is_jr_s, is_jal_s, is_halt_s, is_nop_s;
  logic is_branch_s, is_jump_s, branch_taken_s;

  // Opcode classification plus the purely opcode-driven datapath selects.
  always_comb begin
    is_lw_s   = 1'b0;
    is_sw_s   = 1'b0;
    is_beq_s  = 1'b0;
    is_bne_s  = 1'b0;
    is_bltz_s = 1'b0;
    is_j_s    = 1'b0;
    is_jr_s   = 1'b0;
    is_jal_s  = 1'b0;
    is_halt_s = 1'b0;
    is_nop_s  = 1'b0;
    ALUOp     = 3'b000;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b1;
    DBDataSrc = 1'b0;
    RegDst    = 2'b01;
    WrRegDSrc = 1'b1;
    case (Opcode)
      OP_ADD:   RegDst = 2'b10;
      OP_SUB:   begin ALUOp = 3'b001; RegDst = 2'b10; end
      OP_ADDIU: ALUSrcB = 1'b1;
      OP_AND:   begin ALUOp = 3'b110; RegDst = 2'b10; end
      OP_ANDI:  begin ALUOp = 3'b110; ALUSrcB = 1'b1; ExtSel = 1'b0; end
      OP_ORI:   begin ALUOp = 3'b101; ALUSrcB = 1'b1; ExtSel = 1'b0; end
      OP_SLT:   begin ALUOp = 3'b100; RegDst = 2'b10; end
      OP_SLL:   begin ALUOp = 3'b011; ALUSrcA = 1'b1; RegDst = 2'b10; end
      OP_SW:    begin is_sw_s = 1'b1; ALUSrcB = 1'b1; end
      OP_LW:    begin is_lw_s = 1'b1; ALUSrcB = 1'b1; DBDataSrc = 1'b1; end
      OP_BEQ:   begin is_beq_s = 1'b1; ALUOp = 3'b001; end
      OP_BNE:   begin is_bne_s = 1'b1; ALUOp = 3'b001; end
      OP_BLTZ:  begin is_bltz_s = 1'b1; ALUOp = 3'b001; end
      OP_J:     is_j_s = 1'b1;
      OP_JR:    is_jr_s = 1'b1;
      // jal links PC+4 into $31 from ID
      OP_JAL:   begin is_jal_s = 1'b1; RegDst = 2'b00; WrRegDSrc = 1'b0; end
      OP_HALT:  is_halt_s = 1'b1;
      default:  is_nop_s = 1'b1;
    endcase
  end

  assign is_branch_s    = is_beq_s | is_bne_s | is_bltz_s;
  assign is_jump_s      = is_j_s | is_jr_s | is_jal_s;
  assign branch_taken_s = (is_beq_s & Zero) | (is_bne_s & ~Zero) | (is_bltz_s & Sign);

  // State sequencer; Reset wins from any state, including MEM and HALT.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r <= ST_IF;
    end else begin
      case (state_r)
        ST_IF:   state_r <= ST_ID;
        ST_ID:   state_r <= is_halt_s ? ST_HALT :
                            ((is_jump_s | is_nop_s) ? ST_IF : ST_EXE);
        ST_EXE:  state_r <= is_branch_s ? ST_IF :
                            ((is_lw_s | is_sw_s) ? ST_MEM : ST_WB);
        ST_MEM:  state_r <= MemReady ? (is_lw_s ? ST_WB : ST_IF) : ST_MEM;
        ST_WB:   state_r <= ST_IF;
        ST_HALT: state_r <= ST_HALT;
        default: state_r <= ST_IF;
      endcase
    end
  end

  assign State = state_r;

  // A cycle with Reset high decodes as IF so no write strobe escapes while
  // the sequencer is being pulled back.
  assign dec_state_s = Reset ? ST_IF : state_r;

  // State-dependent strobes. PCWre fires in whichever state hands back to IF.
  always_comb begin
    PCWre  = 1'b0;
    IRWre  = 1'b0;
    RegWre = 1'b0;
    mWR    = 1'b0;
    mRD    = 1'b0;
    PCSrc  = 2'b00;
    case (dec_state_s)
      ST_IF:   IRWre = 1'b1;
      ST_ID: begin
        PCWre  = is_jump_s | is_nop_s;
        RegWre = is_jal_s;
        PCSrc  = (is_j_s | is_jal_s) ? 2'b11 : (is_jr_s ? 2'b10 : 2'b00);
      end
      ST_EXE: begin
        PCWre = is_branch_s;
        PCSrc = branch_taken_s ? 2'b01 : 2'b00;
      end
      ST_MEM: begin
        mWR   = is_sw_s;
        mRD   = is_lw_s;
        // lw continues to WB, anything else finishes here
        PCWre = MemReady & ~is_lw_s;
      end
      ST_WB: begin
        PCWre  = 1'b1;
        RegWre = 1'b1;
      end
      ST_HALT: PCWre = 1'b0;
      default: PCWre = 1'b0;
    endcase
  end

`ifdef MC_INSTR_COUNT_EN
  logic [31:0] count_r;

  // Retired-instruction counter, wraps modulo 2^32.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      count_r <= 32'd0;
    end else if (PCWre) begin
      count_r <= count_r + 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign InstrCount = count_r;
`else
  assign InstrCount = 32'd0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
//   Directed self-checking bench for mc_control_fsm. Each task drives one
//   scenario and compares the observed control vector against hand-derived
//   expectations. InstrCount expectations follow MC_INSTR_COUNT_EN.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [5:0]  Opcode = 6'b000000;
  logic        Zero = 1'b0;
  logic        Sign = 1'b0;
  logic        MemReady = 1'b0;
  logic [2:0]  State;
  logic        PCWre, IRWre, RegWre, mWR, mRD;
  logic        ALUSrcA, ALUSrcB, DBDataSrc, ExtSel, WrRegDSrc;
  logic [1:0]  RegDst, PCSrc;
  logic [2:0]  ALUOp;
  logic [31:0] InstrCount;

  int checks = 0;
  int errors = 0;

`ifdef MC_INSTR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // {State, PCWre, IRWre, RegWre, mWR, mRD, PCSrc}
  logic [9:0] obs;
  assign obs = {State, PCWre, IRWre, RegWre, mWR, mRD, PCSrc};

  mc_control_fsm dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .Sign(Sign),
    .MemReady(MemReady), .State(State), .PCWre(PCWre), .IRWre(IRWre),
    .RegWre(RegWre), .mWR(mWR), .mRD(mRD), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc), .ExtSel(ExtSel),
    .WrRegDSrc(WrRegDSrc), .RegDst(RegDst), .PCSrc(PCSrc), .ALUOp(ALUOp),
    .InstrCount(InstrCount)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One reset edge; returns 1 time unit after the edge with State = IF.
  task automatic do_reset();
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Opcode = 6'b100111; MemReady = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (obs !== 10'b000_01000_00) begin
      errors++; $display("FAIL reset_decode got=%b want=%b", obs, 10'b000_01000_00);
    end
    checks++;
    if (InstrCount !== 32'd0) begin
      errors++; $display("FAIL reset_count got=%0d want=0", InstrCount);
    end
    Reset = 1'b0;
  endtask

  task automatic test_add();
    logic [9:0] exp_v [0:4];
    exp_v = '{10'b000_01000_00, 10'b001_00000_00, 10'b010_00000_00,
              10'b100_10100_00, 10'b000_01000_00};
    do_reset();
    Opcode = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (obs !== exp_v[i]) begin
        errors++; $display("FAIL add cycle %0d got=%b want=%b", i, obs, exp_v[i]);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_lw();
    logic [9:0] exp_v [0:8];
    exp_v = '{10'b000_01000_00, 10'b001_00000_00, 10'b010_00000_00,
              10'b011_00001_00, 10'b011_00001_00, 10'b011_00001_00,
              10'b011_00001_00, 10'b100_10100_00, 10'b000_01000_00};
    do_reset();
    Opcode = 6'b100111;
    for (int i = 0; i < 9; i++) begin
      MemReady = (i == 6) ? 1'b1 : 1'b0;
      #1;
      checks++;
      if (obs !== exp_v[i]) begin
        errors++; $display("FAIL lw cycle %0d got=%b want=%b", i, obs, exp_v[i]);
      end
      if (i == 7) begin
        checks++;
        if (DBDataSrc !== 1'b1) begin
          errors++; $display("FAIL lw_dbdatasrc got=%b want=1", DBDataSrc);
        end
      end
      @(posedge CLK); #1;
    end
    MemReady = 1'b0;
  endtask

  task automatic test_branch();
    logic [5:0] ops [0:4];
    logic       zs  [0:4];
    logic       ss  [0:4];
    logic [1:0] pcs [0:4];
    ops = '{6'b110000, 6'b110000, 6'b110001, 6'b110010, 6'b110010};
    zs  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    ss  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    pcs = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
    for (int i = 0; i < 5; i++) begin
      do_reset();
      Opcode = ops[i]; Zero = zs[i]; Sign = ss[i];
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      #1;
      checks++;
      if (obs !== {8'b010_10000, pcs[i]}) begin
        errors++; $display("FAIL branch %0d exe got=%b want=%b", i, obs, {8'b010_10000, pcs[i]});
      end
      @(posedge CLK); #1;
      checks++;
      if (State !== 3'b000) begin
        errors++; $display("FAIL branch %0d next got=%b want=000", i, State);
      end
    end
    Zero = 1'b0; Sign = 1'b0;
  endtask

  task automatic test_jal();
    do_reset();
    Opcode = 6'b111010;
    @(posedge CLK); #1;
    #1;
    checks++;
    if (obs !== 10'b001_10100_11) begin
      errors++; $display("FAIL jal_id got=%b want=%b", obs, 10'b001_10100_11);
    end
    checks++;
    if ({RegDst, WrRegDSrc} !== 3'b000) begin
      errors++; $display("FAIL jal_link got=%b want=000", {RegDst, WrRegDSrc});
    end
    @(posedge CLK); #1;
    checks++;
    if (State !== 3'b000) begin
      errors++; $display("FAIL jal_next got=%b want=000", State);
    end
  endtask

  task automatic test_halt();
    do_reset();
    Opcode = 6'b111111;
    @(posedge CLK); #1;
    checks++;
    if (obs !== 10'b001_00000_00) begin
      errors++; $display("FAIL halt_id got=%b want=%b", obs, 10'b001_00000_00);
    end
    @(posedge CLK); #1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs !== 10'b101_00000_00) begin
        errors++; $display("FAIL halt cycle %0d got=%b want=%b", i, obs, 10'b101_00000_00);
      end
      @(posedge CLK); #1;
    end
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    checks++;
    if (State !== 3'b000) begin
      errors++; $display("FAIL halt_reset got=%b want=000", State);
    end
  endtask

  // Opcode-only selects: {ALUOp, ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, RegDst, WrRegDSrc}
  task automatic test_decode();
    logic [5:0] ops [0:13];
    logic [9:0] exp_v [0:13];
    ops   = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
              6'b010010, 6'b011000, 6'b011100, 6'b100110, 6'b100111,
              6'b110000, 6'b110010, 6'b111010, 6'b000011};
    exp_v = '{10'b000_0010_10_1, 10'b001_0010_10_1, 10'b000_0110_01_1,
              10'b110_0010_10_1, 10'b110_0100_01_1, 10'b101_0100_01_1,
              10'b100_0010_10_1, 10'b011_1010_10_1, 10'b000_0110_01_1,
              10'b000_0111_01_1, 10'b001_0010_01_1, 10'b001_0010_01_1,
              10'b000_0010_00_0, 10'b000_0010_01_1};
    Reset = 1'b1;
    for (int i = 0; i < 14; i++) begin
      Opcode = ops[i];
      #1;
      checks++;
      if ({ALUOp, ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, RegDst, WrRegDSrc} !== exp_v[i]) begin
        errors++;
        $display("FAIL decode op=%b got=%b want=%b", ops[i],
                 {ALUOp, ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, RegDst, WrRegDSrc}, exp_v[i]);
      end
    end
    @(posedge CLK); #1;
    Reset = 1'b0;
  endtask

  task automatic test_count();
    logic [5:0] ops [0:4];
    int         cyc [0:4];
    ops = '{6'b000000, 6'b100110, 6'b110000, 6'b111000, 6'b100111};
    cyc = '{4, 4, 3, 2, 5};
    do_reset();
    MemReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      Opcode = ops[i];
      repeat (cyc[i]) begin
        @(posedge CLK); #1;
      end
      if (i == 0) begin
        checks++;
        if (InstrCount !== (CNT_EN ? 32'd1 : 32'd0)) begin
          errors++; $display("FAIL count_after_add got=%0d want=%0d", InstrCount, CNT_EN ? 1 : 0);
        end
      end
    end
    checks++;
    if (State !== 3'b000 || InstrCount !== (CNT_EN ? 32'd5 : 32'd0)) begin
      errors++;
      $display("FAIL count_five got state=%b count=%0d want state=000 count=%0d",
               State, InstrCount, CNT_EN ? 5 : 0);
    end
    Opcode = 6'b100111; MemReady = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
    end
    checks++;
    if (State !== 3'b011 || mRD !== 1'b1) begin
      errors++; $display("FAIL count_mem got state=%b mRD=%b want state=011 mRD=1", State, mRD);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if ({IRWre, PCWre, RegWre, mWR, mRD} !== 5'b10000) begin
      errors++; $display("FAIL reset_mid_mem_strobes got=%b want=10000", {IRWre, PCWre, RegWre, mWR, mRD});
    end
    @(posedge CLK); #1;
    Reset = 1'b0;
    checks++;
    if (State !== 3'b000 || InstrCount !== 32'd0) begin
      errors++; $display("FAIL reset_mid_mem got state=%b count=%0d want state=000 count=0", State, InstrCount);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_add();
    test_lw();
    test_branch();
    test_jal();
    test_halt();
    test_decode();
    test_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have port CLK, input, 1, the only clock; all state changes on rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port Opcode, input, 6, opcode field of the instruction register (IR[31:26]).
REQ-004 SHALL have port Zero, input, 1, ALU result == 0.
REQ-005 SHALL have port Sign, input, 1, ALU result bit 31.
REQ-006 SHALL have port MemReady, input, 1, data memory access complete (handshake).
REQ-007 SHALL have port State, output, 3, current state encoding.
REQ-008 SHALL have ports PCWre, IRWre, RegWre, mWR, mRD, output, 1 each: PC write, IR write, register-file write, data-memory write, data-memory read.
REQ-009 SHALL have ports ALUSrcA, ALUSrcB, DBDataSrc, ExtSel, WrRegDSrc, output, 1 each: datapath mux and extend selects.
REQ-010 SHALL have ports RegDst, PCSrc, output, 2 each; ALUOp, output, 3.
REQ-011 SHALL have port InstrCount, output, 32, retired-instruction count (REQ-028).

Function
REQ-012 SHALL decode opcodes: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, slt 011000, sll 011100, sw 100110, lw 100111, beq 110000, bne 110001, bltz 110010, j 111000, jr 111001, jal 111010, halt 111111. All others: NOP.
REQ-013 SHALL use states IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=101. No other state reachable.
REQ-014 SHALL transition IF->ID unconditionally.
REQ-015 SHALL transition from ID: halt->HALT; j/jal/jr/NOP->IF; all others->EXE.
REQ-016 SHALL transition from EXE: beq/bne/bltz->IF; sw/lw->MEM; all others->WB.
REQ-017 SHALL hold in MEM while MemReady=0. When MemReady=1: lw->WB; sw->IF.
REQ-018 SHALL transition WB->IF unconditionally. HALT SHALL be held until Reset.
REQ-019 SHALL make all outputs combinational from State and Opcode (Moore plus opcode decode). No output depends on Zero/Sign except PCSrc in EXE.
REQ-020 SHALL assert IRWre only in IF.
REQ-021 SHALL assert PCWre for exactly one cycle per instruction, in the state whose successor is IF. It is never asserted in HALT, nor while MEM waits.
REQ-022 SHALL assert RegWre only in WB, and in ID for jal (RegDst=00 selects $31, WrRegDSrc=0 selects PC+4).
REQ-023 SHALL assert mWR only in MEM for sw, and mRD only in MEM for lw. Both SHALL be held for every MEM cycle until MemReady.
REQ-024 SHALL drive PCSrc: 00 PC+4; 01 branch target when in EXE and (beq&Zero | bne&~Zero | bltz&Sign); 10 jr; 11 j/jal.
REQ-025 SHALL drive ALUOp: add/addiu/lw/sw=000, sub/beq/bne/bltz=001, sll=011, ori=101, and/andi=110, slt=100.
REQ-026 SHALL drive ALUSrcB=1 for addiu/andi/ori/lw/sw, ALUSrcA=1 for sll, and ExtSel=0 for andi/ori (zero-extend), 1 otherwise. DBDataSrc=1 for lw only. RegDst=10 for R-type, 01 for I-type.

Reset
REQ-027 SHALL, on any clock edge with Reset=1 (including mid-MEM or in HALT), load State=IF and InstrCount=0. During the Reset cycle, outputs SHALL be the IF decode with PCWre=RegWre=mWR=mRD=0.

Configuration
REQ-028 SHALL implement macro MC_INSTR_COUNT_EN. When defined: InstrCount increments by 1 on each edge where PCWre=1 (modulo 2^32). When undefined: InstrCount is tied to 0 and no counter register exists.

Verification
REQ-029 SHALL verify add: Reset then Opcode=000000 -> states IF,ID,EXE,WB,IF; RegWre=1 only in WB; PCWre=1 in WB; 4 cycles.
REQ-030 SHALL verify lw with MemReady low for 3 cycles -> MEM held 4 cycles with mRD=1 throughout, then WB. RegWre=1, DBDataSrc=1. Total 8 cycles.
REQ-031 SHALL verify beq: Zero=1 -> PCSrc=01 in EXE; Zero=0 -> PCSrc=00. Either way, EXE->IF with PCWre=1, RegWre=0.
REQ-032 SHALL verify jal -> ID->IF; in ID: RegWre=1, RegDst=00, PCSrc=11, PCWre=1.
REQ-033 SHALL verify halt -> HALT held 10 cycles with PCWre=0. Then Reset=1 -> State=000 next edge.
REQ-034 SHALL verify, with MC_INSTR_COUNT_EN defined, that 5 instructions (add, sw, beq, j, lw) give InstrCount=5. Reset asserted mid-MEM -> InstrCount=0, State=IF.
